// File: rtl/data_mem_resp_if.sv
// Load/store request bus between the core (master) and a data-side memory responder (slave).
// Latency: none (wires only).
// Backpressure: the master holds req/we/be/addr/wdata stable until it sees gnt; rvalid cannot be stalled.
//
// Signal suffixes are from the slave's point of view: _i = driven by the core, _o = driven by the memory.
interface data_mem_resp_if;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/data_mem_resp.sv
// Data-side memory responder: word array behind the core's load/store bus, with programmable wait states.
// Latency: request seen in IDLE at T with stall N -> gnt at T+N+1, rvalid at T+N+2, next request at T+N+3 at the earliest.
// Backpressure: one request in flight; the core must hold req until gnt; dropping req during wait states aborts it.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   bus (slave)       req/we/be/addr/wdata in; gnt/rvalid/rdata/err out
//   stall_cycles_i    wait states before grant, sampled when the request is accepted
//   busy_o            high whenever the FSM is not in IDLE
//   load_cnt_o        completed loads (error-free), saturating
//   store_cnt_o       completed stores (error-free), saturating
module data_mem_resp #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_resp_if.slave       bus,
    input  logic [3:0]           stall_cycles_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] load_cnt_o,
    output logic [CNT_WIDTH-1:0] store_cnt_o
);

    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    // Span in bytes; one extra bit so a 2**30-word array still compares correctly.
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e               state_q,     state_d;
    logic [3:0]           stall_cnt_q, stall_cnt_d;
    logic                 we_q,        we_d;
    logic [3:0]           be_q,        be_d;
    logic [31:0]          addr_q,      addr_d;
    logic [31:0]          wdata_q,     wdata_d;
    logic [31:0]          rdata_q,     rdata_d;
    logic                 err_q,       err_d;
    logic [CNT_WIDTH-1:0] load_cnt_q,  load_cnt_d;
    logic [CNT_WIDTH-1:0] store_cnt_q, store_cnt_d;

    // Word array; deliberately not reset so contents survive a reset pulse.
    logic [31:0] mem [DEPTH];

    // Address decode works on the latched request so it is stable for the whole transaction.
    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  mem_wr_en;

    assign offset    = addr_q - BASE_ADDR;
    assign in_range  = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN_BYTES);
    assign word_idx  = offset[ADDR_WIDTH+1:2];
    assign mem_wr_en = (state_q == S_ACCESS) && we_q && in_range;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // Byte-lane write; lanes with be=0 keep their old contents.
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.data_req_i) begin
                    we_d        = bus.data_we_i;
                    be_d        = bus.data_be_i;
                    addr_d      = bus.data_addr_i;
                    wdata_d     = bus.data_wdata_i;
                    stall_cnt_d = stall_cycles_i;
                    state_d     = (stall_cycles_i != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!bus.data_req_i) begin
                    // Core withdrew the request: nothing performed, nothing counted.
                    state_d = S_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q - 4'd1;
                    if (stall_cnt_q == 4'd1) begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // Stores and errors respond with zero data.
                rdata_d = (!we_q && in_range) ? mem[word_idx] : 32'h0;
                err_d   = !in_range;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!err_q) begin
                    if (we_q) begin
                        if (store_cnt_q != '1) store_cnt_d = store_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        if (load_cnt_q != '1) load_cnt_d = load_cnt_q + CNT_WIDTH'(1);
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.data_gnt_o    = 1'b0;
        bus.data_rvalid_o = 1'b0;
        bus.data_rdata_o  = 32'h0;
        bus.data_err_o    = 1'b0;
        busy_o            = (state_q != S_IDLE);
        load_cnt_o        = load_cnt_q;
        store_cnt_o       = store_cnt_q;

        if (state_q == S_ACCESS) begin
            bus.data_gnt_o = 1'b1;
        end
        // Response fields are forced to zero outside the rvalid cycle.
        if (state_q == S_RESP) begin
            bus.data_rvalid_o = 1'b1;
            bus.data_rdata_o  = rdata_q;
            bus.data_err_o    = err_q;
        end
    end

endmodule
